// File: rtl/req_grant_pkg.sv
// ============================================================================
// Module   : req_grant_pkg
// Purpose  : Shared types and helpers for the round-robin request/grant arbiter.
// Config   : REQ_GRANT_SVA_EN (used by req_grant_rr_arbiter; nothing here)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package req_grant_pkg;

  // Grant latency selection: combinational grant or registered grant
  typedef enum logic [0:0] {
    GNT_COMB = 1'b0,
    GNT_REG  = 1'b1
  } gnt_lat_e;

  // Index width for an N-entry vector; never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// ============================================================================
// Module   : rr_priority_pick
// Purpose  : Rotating-priority one-hot picker. Returns the first candidate
//            (req & mask) found scanning upward from i_ptr, wrapping at NUM_REQ.
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_pick
  import req_grant_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic [NUM_REQ-1:0] i_mask,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_found
);

  logic [NUM_REQ-1:0] w_cand;

  assign w_cand = i_req & i_mask;

  // Scan candidates from the pointer upward and keep only the first hit
  always_comb begin
    int w_j;
    w_j      = 0;
    o_onehot = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= NUM_REQ) begin
        w_j = w_j - NUM_REQ;
      end
      if (!o_found && w_cand[IDX_W'(w_j)]) begin
        o_found                 = 1'b1;
        o_onehot[IDX_W'(w_j)]   = 1'b1;
        o_idx                   = IDX_W'(w_j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/req_grant_rr_arbiter.sv
// ============================================================================
// Module   : req_grant_rr_arbiter
// Purpose  : N-way round-robin request/grant arbiter with bounded hold time
//            per owner and selectable grant latency (0 = combinational,
//            1 = registered).
// Config   : REQ_GRANT_SVA_EN - when defined, compiles the built-in
//            concurrent assertion checker. Datapath is identical either way.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_grant_rr_arbiter
  import req_grant_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int GNT_LATENCY = 1,
  parameter  int MAX_HOLD    = 8,
  localparam int IDX_W       = idx_w(NUM_REQ),
  localparam int HOLD_W      = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_id,
  output logic [HOLD_W-1:0]  hold_cnt
);

  localparam logic [HOLD_W-1:0] C_HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0]  C_IDX_LAST = IDX_W'(NUM_REQ - 1);

  // Arbitration state
  logic [IDX_W-1:0]   r_owner;
  logic               r_busy;
  logic [HOLD_W-1:0]  r_hold;
  logic [IDX_W-1:0]   r_ptr;

  // Decision for the current cycle
  logic [IDX_W-1:0]   w_d_owner;
  logic               w_d_busy;
  logic [HOLD_W-1:0]  w_d_hold;
  logic [IDX_W-1:0]   w_d_ptr;
  logic [NUM_REQ-1:0] w_d_oh;

  logic [NUM_REQ-1:0] w_owner_oh;
  logic               w_others;
  logic               w_owner_req;
  logic               w_keep;
  logic               w_forced;
  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_pick_oh;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_found;

  // One-hot view of the current owner index
  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
  end

  assign w_owner_req = r_busy && req[r_owner];
  assign w_others    = |(req & ~w_owner_oh);
  // Owner keeps the grant until its hold budget is spent, unless nobody else wants it
  assign w_keep      = w_owner_req && ((r_hold < C_HOLD_MAX) || !w_others);
  // An owner still requesting but out of budget is excluded from this pick
  assign w_forced    = w_owner_req && (r_hold >= C_HOLD_MAX) && w_others;
  assign w_mask      = w_forced ? ~w_owner_oh : '1;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .i_mask   (w_mask),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_found  (w_pick_found)
  );

  // Next-state decision: keep owner, hand over to next in rotation, or go idle
  always_comb begin
    w_d_owner = r_owner;
    w_d_busy  = 1'b0;
    w_d_hold  = '0;
    w_d_ptr   = r_ptr;
    w_d_oh    = '0;
    if (w_keep) begin
      w_d_busy = 1'b1;
      w_d_hold = (r_hold == C_HOLD_MAX) ? r_hold : r_hold + 1'b1;
      w_d_oh   = w_owner_oh;
    end else if (w_pick_found) begin
      w_d_owner = w_pick_idx;
      w_d_busy  = 1'b1;
      w_d_hold  = HOLD_W'(1);
      w_d_ptr   = (w_pick_idx == C_IDX_LAST) ? '0 : w_pick_idx + 1'b1;
      w_d_oh    = w_pick_oh;
    end
  end

  // State register: reset clears everything, otherwise follow the decision
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner <= '0;
      r_busy  <= 1'b0;
      r_hold  <= '0;
      r_ptr   <= '0;
    end else begin
      r_owner <= w_d_owner;
      r_busy  <= w_d_busy;
      r_hold  <= w_d_hold;
      r_ptr   <= w_d_ptr;
    end
  end

  // Latency mux: present the decision directly, or the registered state
  if (GNT_LATENCY == int'(GNT_COMB)) begin : g_lat_comb
    // Outputs are held at zero while reset is asserted
    assign gnt      = rst_n ? w_d_oh : '0;
    assign gnt_id   = (rst_n && w_d_busy) ? w_d_owner : '0;
    assign hold_cnt = rst_n ? w_d_hold : '0;
  end else begin : g_lat_reg
    assign gnt      = r_busy ? w_owner_oh : '0;
    assign gnt_id   = r_busy ? r_owner : '0;
    assign hold_cnt = r_hold;
  end

  assign gnt_valid = |gnt;

`ifdef REQ_GRANT_SVA_EN
  localparam int C_FAIR_BOUND = (NUM_REQ - 1) * MAX_HOLD + GNT_LATENCY + 1;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_gnt_valid:   assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == |gnt);
  a_hold_max:    assert property (@(posedge clk) disable iff (!rst_n) hold_cnt <= C_HOLD_MAX);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sva_bit
    if (GNT_LATENCY == int'(GNT_COMB)) begin : g_sva_comb
      a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
        !req[gi] |-> !gnt[gi]);
    end else begin : g_sva_reg
      a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
        !req[gi] |=> !gnt[gi]);
    end
    a_fairness: assert property (@(posedge clk) disable iff (!rst_n)
      (req[gi] && !gnt[gi]) |-> ##[0:C_FAIR_BOUND] (gnt[gi] || !req[gi]));
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_req_grant_rr_arbiter.sv
// ============================================================================
// Module   : tb_req_grant_rr_arbiter
// Purpose  : Scoreboard bench driving one combinational-grant and one
//            registered-grant arbiter with the same directed request vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_req_grant_rr_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;

  logic [3:0] gnt0, gnt1;
  logic       gv0, gv1;
  logic [1:0] id0, id1;
  logic [3:0] hc0, hc1;

  // Expected outputs of both arbiters for one cycle
  typedef struct packed {
    logic [3:0] g0;
    logic [3:0] h0;
    logic [3:0] g1;
    logic [3:0] h1;
  } exp_t;

  exp_t       q[$];
  logic [3:0] pg = 4'b0000;
  logic [3:0] ph = 4'b0000;
  int         total = 0;
  int         bad = 0;
  int         tnum = 0;

  always #5 clk = ~clk;

  req_grant_rr_arbiter #(.NUM_REQ(N), .GNT_LATENCY(0), .MAX_HOLD(MH)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt0), .gnt_valid(gv0), .gnt_id(id0), .hold_cnt(hc0));

  req_grant_rr_arbiter #(.NUM_REQ(N), .GNT_LATENCY(1), .MAX_HOLD(MH)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt1), .gnt_valid(gv1), .gnt_id(id1), .hold_cnt(hc1));

  function automatic logic [1:0] id_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL t%0d %s: got %b expected %b at %0t", tnum, nm, act, exp_v, $time);
    end
  endtask

  // Drive one cycle of stimulus; dg/dh is the hand-computed decision for it
  task automatic step(input logic rn, input logic [3:0] r,
                      input logic [3:0] dg, input logic [3:0] dh);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn;
    req   = r;
    e.g0  = rn ? dg : 4'b0000;
    e.h0  = rn ? dh : 4'b0000;
    e.g1  = pg;
    e.h1  = ph;
    q.push_back(e);
    pg = rn ? dg : 4'b0000;
    ph = rn ? dh : 4'b0000;
  endtask

  // Monitor: pop and compare every cycle an expectation is pending
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt0",   gnt0,            e.g0);
        chk("valid0", {3'b0, gv0},     {3'b0, |e.g0});
        chk("id0",    {2'b0, id0},     {2'b0, id_of(e.g0)});
        chk("hold0",  hc0,             e.h0);
        chk("gnt1",   gnt1,            e.g1);
        chk("valid1", {3'b0, gv1},     {3'b0, |e.g1});
        chk("id1",    {2'b0, id1},     {2'b0, id_of(e.g1)});
        chk("hold1",  hc1,             e.h1);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    // reset state
    tnum = 0;
    step(1'b0, 4'b0000, 4'b0000, 4'd0);
    step(1'b0, 4'b0000, 4'b0000, 4'd0);

    // single requester 0
    tnum = 1;
    step(1'b1, 4'b0000, 4'b0000, 4'd0);
    step(1'b1, 4'b0001, 4'b0001, 4'd1);
    step(1'b1, 4'b0001, 4'b0001, 4'd2);
    step(1'b1, 4'b0001, 4'b0001, 4'd3);
    step(1'b1, 4'b0000, 4'b0000, 4'd0);
    step(1'b0, 4'b0000, 4'b0000, 4'd0);

    // all requesting: MAX_HOLD rotation and wrap back to 0
    tnum = 2;
    for (int o = 0; o < 4; o++)
      for (int h = 1; h <= MH; h++)
        step(1'b1, 4'b1111, 4'(1 << o), 4'(h));
    step(1'b1, 4'b1111, 4'b0001, 4'd1);
    step(1'b1, 4'b1111, 4'b0001, 4'd2);
    step(1'b0, 4'b0000, 4'b0000, 4'd0);

    // owner withdrawal hands over with no bubble; idle keeps pointer
    tnum = 3;
    step(1'b1, 4'b0011, 4'b0001, 4'd1);
    step(1'b1, 4'b0011, 4'b0001, 4'd2);
    step(1'b1, 4'b0011, 4'b0001, 4'd3);
    step(1'b1, 4'b0010, 4'b0010, 4'd1);
    step(1'b1, 4'b0010, 4'b0010, 4'd2);
    step(1'b1, 4'b0000, 4'b0000, 4'd0);
    step(1'b1, 4'b0011, 4'b0001, 4'd1);
    step(1'b1, 4'b1111, 4'b0001, 4'd2);
    step(1'b0, 4'b0000, 4'b0000, 4'd0);

    // sole requester: grant forever, hold saturates at MAX_HOLD
    tnum = 4;
    for (int k = 1; k <= 20; k++)
      step(1'b1, 4'b0100, 4'b0100, 4'((k < MH) ? k : MH));
    step(1'b0, 4'b0000, 4'b0000, 4'd0);

    // reset mid-grant drops the grant and restarts from requester 0
    tnum = 5;
    for (int h = 1; h <= MH; h++)
      step(1'b1, 4'b1111, 4'b0001, 4'(h));
    step(1'b1, 4'b1111, 4'b0010, 4'd1);
    step(1'b1, 4'b1111, 4'b0010, 4'd2);
    step(1'b0, 4'b1111, 4'b0000, 4'd0);
    step(1'b1, 4'b1111, 4'b0001, 4'd1);
    step(1'b1, 4'b1111, 4'b0001, 4'd2);
    step(1'b1, 4'b0000, 4'b0000, 4'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    tnum = 99;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL t%0d drain: got %0d pending expected 0", tnum, q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
